w0rm_core_reg_write_arbiter: RTL and testbench
==============================================

W0RM_CORE_REG_WRITE_ARBITER -- requirements
Module: w0rm_core_reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter NUM_REGISTERS, default 16, meaning register count.
REQ-003 The block SHALL have a derived localparam REG_ADDR_BITS equal to ceil(log2(NUM_REGISTERS)), which is 4 at default.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports in order: clk in 1 (sole clock, rising edge); reset in 1 (synchronous, active-high).
REQ-005 The block SHALL provide one request channel per requester r in {alu, mem, link}:
- r_wr_valid in 1: write request.
- r_wr_addr in REG_ADDR_BITS: destination register.
- r_wr_data in DATA_WIDTH: write data.
- r_wr_ready out 1: request accepted at the clock edge where valid and ready are both high.
REQ-006 The block SHALL provide the register-file write port:
- port_write_enable out 1.
- port_write_addr out REG_ADDR_BITS.
- port_write_data out DATA_WIDTH.
REQ-007 The block SHALL provide pending_mask out NUM_REGISTERS, where bit n set means a write to register n is not yet committed.

Function
REQ-008 Each requester SHALL own a one-entry holding register (valid, addr, data), which is loaded on handshake.
REQ-009 r_wr_ready SHALL equal (holding entry empty) OR (holding entry granted this cycle); it SHALL be combinational from internal state only and never from r_wr_valid.
REQ-010 Each cycle the arbiter SHALL grant at most one valid holding entry; a granted entry SHALL clear at the next edge unless reloaded by a simultaneous handshake, in which case the entry holds the new request.
REQ-011 A granted entry SHALL appear on port_write_* as registered outputs, with port_write_enable high for exactly one cycle, beginning the cycle after the grant.
REQ-012 The minimum latency from accept edge to port_write_enable SHALL be 1 cycle (accept edge N, grant in cycle N+1, enable high after edge N+1).
REQ-013 When no entry is valid, port_write_enable SHALL be 0, and port_write_addr/data SHALL hold their last values.
REQ-014 pending_mask SHALL be the OR of decoded addresses of all valid holding entries plus port_write_addr while port_write_enable is high.
REQ-015 Two entries targeting the same address SHALL both be written, in grant order; the arbiter SHALL provide no further ordering guarantee.
REQ-016 Sustained throughput SHALL be one write per cycle in aggregate; each requester SHALL be limited to one write per cycle when uncontended.
REQ-017 Grant selection SHALL follow REQ-023/REQ-024.

Reset
REQ-018 While reset is high at a clock edge, all holding entries SHALL clear and no handshake SHALL complete.
REQ-019 After a reset edge, port_write_enable SHALL be 0, port_write_addr SHALL be 0, port_write_data SHALL be 0, and pending_mask SHALL be 0.
REQ-020 After a reset edge, all r_wr_ready outputs SHALL be 1 in the following cycle.
REQ-021 Reset mid-operation SHALL discard pending entries without writing them, including any grant in the same cycle.
REQ-022 After a reset edge, the round-robin pointer SHALL be last-granted=link.

Configuration
REQ-023 With macro W0RM_REGWR_ARB_ROUND_ROBIN_EN defined, grant SHALL be round-robin in order alu -> mem -> link -> alu, starting after the last granted requester.
REQ-024 Without W0RM_REGWR_ARB_ROUND_ROBIN_EN, grant SHALL be fixed priority mem > alu > link, and the pointer logic SHALL be absent.

Verification
REQ-025 Single request: alu writes addr 3, data 0xDEADBEEF at edge N -> port_write_enable=1, addr=3, data=0xDEADBEEF, high after edge N+1 for exactly one cycle; pending_mask bit 3 set from edge N through the enable cycle.
REQ-026 Three-way collision: all three requesters are valid in the same cycle (addrs 1, 2, 3) -> writes issue on 3 consecutive cycles in order alu, mem, link with RR enabled, or mem, alu, link without RR; no ready drops below one accept per requester per 3 cycles.
REQ-027 Back-to-back streaming: alu valid every cycle for 8 cycles, other requesters idle -> alu_wr_ready stays 1, and 8 consecutive enable cycles occur with matching data.
REQ-028 Same-address: mem and alu both target addr 5 in the same cycle -> two writes to addr 5 in grant order; pending_mask bit 5 clears only after the second enable cycle.
REQ-029 Reset mid-operation: three entries are pending and reset is asserted for one edge -> no port_write_enable follows, pending_mask=0, all readies=1; the next alu request writes first.

Source files
------------

// File: rtl/w0rm_core_reg_write_arbiter.sv
// Register-file write arbiter: three requesters (alu, mem, link), each with a one-entry holding slot.
// Define W0RM_REGWR_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority mem > alu > link.
module w0rm_core_reg_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 16,
  localparam int REG_ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     alu_wr_valid,
  input  logic [REG_ADDR_BITS-1:0] alu_wr_addr,
  input  logic [DATA_WIDTH-1:0]    alu_wr_data,
  output logic                     alu_wr_ready,

  input  logic                     mem_wr_valid,
  input  logic [REG_ADDR_BITS-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic                     mem_wr_ready,

  input  logic                     link_wr_valid,
  input  logic [REG_ADDR_BITS-1:0] link_wr_addr,
  input  logic [DATA_WIDTH-1:0]    link_wr_data,
  output logic                     link_wr_ready,

  output logic                     port_write_enable,
  output logic [REG_ADDR_BITS-1:0] port_write_addr,
  output logic [DATA_WIDTH-1:0]    port_write_data,

  output logic [NUM_REGISTERS-1:0] pending_mask
);

  localparam int         NREQ = 3;
  localparam logic [1:0] ALU  = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] LINK = 2'd2;

  logic [NREQ-1:0]          req_vld;
  logic [REG_ADDR_BITS-1:0] req_addr [NREQ];
  logic [DATA_WIDTH-1:0]    req_data [NREQ];

  logic [NREQ-1:0]          hold_vld_p0;
  logic [REG_ADDR_BITS-1:0] hold_addr_p0 [NREQ];
  logic [DATA_WIDTH-1:0]    hold_data_p0 [NREQ];

  logic [NREQ-1:0]          grant;
  logic [1:0]               gnt_idx;
  logic [NREQ-1:0]          ready;
  logic [NREQ-1:0]          accept;

  assign req_vld      = {link_wr_valid, mem_wr_valid, alu_wr_valid};
  assign req_addr[0]  = alu_wr_addr;
  assign req_addr[1]  = mem_wr_addr;
  assign req_addr[2]  = link_wr_addr;
  assign req_data[0]  = alu_wr_data;
  assign req_data[1]  = mem_wr_data;
  assign req_data[2]  = link_wr_data;

  // A slot can take a new request when empty or when it drains this cycle.
  assign ready         = ~hold_vld_p0 | grant;
  assign accept        = req_vld & ready;
  assign alu_wr_ready  = ready[ALU];
  assign mem_wr_ready  = ready[MEM];
  assign link_wr_ready = ready[LINK];

`ifdef W0RM_REGWR_ARB_ROUND_ROBIN_EN
  logic [1:0] last_gnt;

  always_comb begin
    logic [1:0] idx;
    grant   = '0;
    gnt_idx = ALU;
    idx     = ALU;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((int'(last_gnt) + k) % NREQ);
      if (grant == '0 && hold_vld_p0[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_gnt <= LINK;
    else if (|grant)
      last_gnt <= gnt_idx;
  end
`else
  always_comb begin
    grant   = '0;
    gnt_idx = MEM;
    if (hold_vld_p0[MEM]) begin
      grant[MEM] = 1'b1;
      gnt_idx    = MEM;
    end else if (hold_vld_p0[ALU]) begin
      grant[ALU] = 1'b1;
      gnt_idx    = ALU;
    end else if (hold_vld_p0[LINK]) begin
      grant[LINK] = 1'b1;
      gnt_idx     = LINK;
    end
  end
`endif

  // Stage p0: holding slots, loaded on handshake, cleared once granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_p0 <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i])
          hold_vld_p0[i] <= 1'b1;
        else if (grant[i])
          hold_vld_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        hold_addr_p0[i] <= req_addr[i];
        hold_data_p0[i] <= req_data[i];
      end
    end
  end

  // Stage p1: registered write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_write_enable <= 1'b0;
      port_write_addr   <= '0;
      port_write_data   <= '0;
    end else begin
      port_write_enable <= |grant;
      if (|grant) begin
        port_write_addr <= hold_addr_p0[gnt_idx];
        port_write_data <= hold_data_p0[gnt_idx];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int n = 0; n < NUM_REGISTERS; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (hold_vld_p0[i] && hold_addr_p0[i] == REG_ADDR_BITS'(n))
          pending_mask[n] = 1'b1;
      end
      if (port_write_enable && port_write_addr == REG_ADDR_BITS'(n))
        pending_mask[n] = 1'b1;
    end
  end

endmodule

// File: tb/tb_w0rm_core_reg_write_arbiter.sv
// Directed bench for w0rm_core_reg_write_arbiter: reset, single write, collision,
// streaming, same-address ordering and mid-operation reset.
module tb_w0rm_core_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr_valid, mem_wr_valid, link_wr_valid;
  logic [3:0]  alu_wr_addr, mem_wr_addr, link_wr_addr;
  logic [31:0] alu_wr_data, mem_wr_data, link_wr_data;
  logic        alu_wr_ready, mem_wr_ready, link_wr_ready;
  logic        port_write_enable;
  logic [3:0]  port_write_addr;
  logic [31:0] port_write_data;
  logic [15:0] pending_mask;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  w0rm_core_reg_write_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .alu_wr_valid      (alu_wr_valid),
    .alu_wr_addr       (alu_wr_addr),
    .alu_wr_data       (alu_wr_data),
    .alu_wr_ready      (alu_wr_ready),
    .mem_wr_valid      (mem_wr_valid),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_ready      (mem_wr_ready),
    .link_wr_valid     (link_wr_valid),
    .link_wr_addr      (link_wr_addr),
    .link_wr_data      (link_wr_data),
    .link_wr_ready     (link_wr_ready),
    .port_write_enable (port_write_enable),
    .port_write_addr   (port_write_addr),
    .port_write_data   (port_write_data),
    .pending_mask      (pending_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [3:0] a, input logic [31:0] d);
    chk({tag, "_en"},   64'(port_write_enable), 64'(1'b1));
    chk({tag, "_addr"}, 64'(port_write_addr),   64'(a));
    chk({tag, "_data"}, 64'(port_write_data),   64'(d));
  endtask

  task automatic idle_inputs();
    alu_wr_valid  = 1'b0; mem_wr_valid = 1'b0; link_wr_valid = 1'b0;
    alu_wr_addr   = '0;   mem_wr_addr  = '0;   link_wr_addr  = '0;
    alu_wr_data   = '0;   mem_wr_data  = '0;   link_wr_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_en",    64'(port_write_enable), 64'(0));
    chk("rst_addr",  64'(port_write_addr),   64'(0));
    chk("rst_data",  64'(port_write_data),   64'(0));
    chk("rst_pend",  64'(pending_mask),      64'(0));
    chk("rst_ready", 64'({link_wr_ready, mem_wr_ready, alu_wr_ready}), 64'(3'b111));

    // Single alu write: addr 3, 0xDEADBEEF
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd3; alu_wr_data = 32'hDEADBEEF;
    tick();
    alu_wr_valid = 1'b0;
    chk("single_pend_held", 64'(pending_mask),      64'(16'h0008));
    chk("single_en_early",  64'(port_write_enable), 64'(0));
    chk("single_ready",     64'(alu_wr_ready),      64'(1));
    tick();
    chk_write("single_wr", 4'd3, 32'hDEADBEEF);
    chk("single_pend_en",   64'(pending_mask),      64'(16'h0008));
    tick();
    chk("single_en_off",    64'(port_write_enable), 64'(0));
    chk("single_addr_hold", 64'(port_write_addr),   64'(3));
    chk("single_data_hold", 64'(port_write_data),   64'(32'hDEADBEEF));
    chk("single_pend_off",  64'(pending_mask),      64'(0));

    // Three-way collision from a fresh reset (pointer at link)
    do_reset();
    alu_wr_valid  = 1'b1; alu_wr_addr  = 4'd1; alu_wr_data  = 32'hA1;
    mem_wr_valid  = 1'b1; mem_wr_addr  = 4'd2; mem_wr_data  = 32'hA2;
    link_wr_valid = 1'b1; link_wr_addr = 4'd3; link_wr_data = 32'hA3;
    tick();
    idle_inputs();
    chk("coll_pend", 64'(pending_mask), 64'(16'h000E));
`ifdef W0RM_REGWR_ARB_ROUND_ROBIN_EN
    chk("coll_ready", 64'({link_wr_ready, mem_wr_ready, alu_wr_ready}), 64'(3'b001));
    tick(); chk_write("coll_w0", 4'd1, 32'hA1);
    tick(); chk_write("coll_w1", 4'd2, 32'hA2);
`else
    chk("coll_ready", 64'({link_wr_ready, mem_wr_ready, alu_wr_ready}), 64'(3'b010));
    tick(); chk_write("coll_w0", 4'd2, 32'hA2);
    tick(); chk_write("coll_w1", 4'd1, 32'hA1);
`endif
    tick(); chk_write("coll_w2", 4'd3, 32'hA3);
    tick();
    chk("coll_en_off", 64'(port_write_enable), 64'(0));
    chk("coll_pend_off", 64'(pending_mask), 64'(0));

    // Back-to-back alu streaming, 8 writes to addr 7
    for (int i = 0; i < 8; i++) begin
      alu_wr_valid = 1'b1; alu_wr_addr = 4'd7; alu_wr_data = 32'h100 + 32'(i);
      chk("stream_ready", 64'(alu_wr_ready), 64'(1));
      tick();
      if (i > 0) chk_write("stream_wr", 4'd7, 32'h100 + 32'(i - 1));
    end
    idle_inputs();
    tick();
    chk_write("stream_last", 4'd7, 32'h107);
    tick();
    chk("stream_en_off", 64'(port_write_enable), 64'(0));

    // Same address from alu and mem: mem is granted first in both modes here
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd5; alu_wr_data = 32'hA5;
    mem_wr_valid = 1'b1; mem_wr_addr = 4'd5; mem_wr_data = 32'hB5;
    tick();
    idle_inputs();
    chk("same_pend0", 64'(pending_mask), 64'(16'h0020));
    tick();
    chk_write("same_w0", 4'd5, 32'hB5);
    chk("same_pend1", 64'(pending_mask), 64'(16'h0020));
    tick();
    chk_write("same_w1", 4'd5, 32'hA5);
    chk("same_pend2", 64'(pending_mask), 64'(16'h0020));
    tick();
    chk("same_en_off", 64'(port_write_enable), 64'(0));
    chk("same_pend3",  64'(pending_mask),      64'(0));

    // Reset with three pending entries and a live grant; alu request held during reset
    alu_wr_valid  = 1'b1; alu_wr_addr  = 4'd8;  alu_wr_data  = 32'hC8;
    mem_wr_valid  = 1'b1; mem_wr_addr  = 4'd9;  mem_wr_data  = 32'hC9;
    link_wr_valid = 1'b1; link_wr_addr = 4'd10; link_wr_data = 32'hCA;
    tick();
    idle_inputs();
    chk("mid_pend", 64'(pending_mask), 64'(16'h0700));
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd15; alu_wr_data = 32'hFF;
    do_reset();
    idle_inputs();
    chk("mid_en",    64'(port_write_enable), 64'(0));
    chk("mid_addr",  64'(port_write_addr),   64'(0));
    chk("mid_data",  64'(port_write_data),   64'(0));
    chk("mid_pend0", 64'(pending_mask),      64'(0));
    chk("mid_ready", 64'({link_wr_ready, mem_wr_ready, alu_wr_ready}), 64'(3'b111));
    tick();
    chk("mid_en_after",   64'(port_write_enable), 64'(0));
    chk("mid_pend_after", 64'(pending_mask),      64'(0));
    alu_wr_valid = 1'b1; alu_wr_addr = 4'd12; alu_wr_data = 32'hC0DE;
    tick();
    idle_inputs();
    chk("post_pend", 64'(pending_mask), 64'(16'h1000));
    tick();
    chk_write("post_wr", 4'd12, 32'hC0DE);
    tick();
    chk("post_en_off", 64'(port_write_enable), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
